onehot_demux_stream: RTL and testbench

Streaming 1-to-8 demultiplexer, the write-side counterpart of the one-hot 8:1 read mux. Accepts one data word plus a 3-bit binary destination select on a valid/ready input channel. Decodes the select to one-hot and steers the word to exactly one of eight valid/ready output lanes through a 2-entry skid buffer. Sits in front of eight independent consumers: input `I_ready` comes from a register, and input-to-output ordering is strict FIFO.

---
 rtl/onehot_demux_pkg.sv | 19 +
 rtl/onehot_decoder.sv | 27 ++
 rtl/onehot_demux_stream.sv | 140 ++++++++++++++
 tb/tb_onehot_demux_stream.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/onehot_demux_pkg.sv
// Shared definitions for the one-hot streaming demultiplexer.
//   N_LANES       : number of output lanes
//   SEL_W         : width of the binary lane select
//   lane_onehot_t : one-hot lane vector (one bit per output lane)
//   buf_state_e   : occupancy of the head/skid buffer
package onehot_demux_pkg;

   localparam int N_LANES = 8;
   localparam int SEL_W   = 3;

   typedef logic [N_LANES-1:0] lane_onehot_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

endpackage : onehot_demux_pkg

// File: rtl/onehot_decoder.sv
// Combinational binary-to-one-hot lane decoder.
//   sel_i    : binary lane select
//   onehot_o : one-hot lane vector, all zero for a non-decodable select
module onehot_decoder
   import onehot_demux_pkg::*;
(
   input  logic [SEL_W-1:0] sel_i,
   output lane_onehot_t     onehot_o
);

   // Decode the select; X/Z selects fall to the all-zero default.
   always_comb begin
      onehot_o = 8'b0000_0000;
      case (sel_i)
         3'd0:    onehot_o = 8'b0000_0001;
         3'd1:    onehot_o = 8'b0000_0010;
         3'd2:    onehot_o = 8'b0000_0100;
         3'd3:    onehot_o = 8'b0000_1000;
         3'd4:    onehot_o = 8'b0001_0000;
         3'd5:    onehot_o = 8'b0010_0000;
         3'd6:    onehot_o = 8'b0100_0000;
         3'd7:    onehot_o = 8'b1000_0000;
         default: onehot_o = 8'b0000_0000;
      endcase
   end

endmodule : onehot_decoder

// File: rtl/onehot_demux_stream.sv
// Streaming 1-to-8 demultiplexer with a 2-entry (head + skid) buffer.
//   CLK, ASYNCRESET : clock, asynchronous active-high reset
//   I, S, I_valid   : input word, binary lane select, input valid
//   I_ready         : registered input ready
//   O0..O7          : lane data, zero on every lane that is not valid
//   O_valid         : per-lane valid, one-hot or zero
//   O_ready         : per-lane ready; only the valid lane's bit is honoured
// Words leave strictly in acceptance order, so a stalled lane blocks all
// following words.
module onehot_demux_stream
   import onehot_demux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             CLK,
   input  logic             ASYNCRESET,
   input  logic [WIDTH-1:0] I,
   input  logic [SEL_W-1:0] S,
   input  logic             I_valid,
   output logic             I_ready,
   output logic [WIDTH-1:0] O0,
   output logic [WIDTH-1:0] O1,
   output logic [WIDTH-1:0] O2,
   output logic [WIDTH-1:0] O3,
   output logic [WIDTH-1:0] O4,
   output logic [WIDTH-1:0] O5,
   output logic [WIDTH-1:0] O6,
   output logic [WIDTH-1:0] O7,
   output lane_onehot_t     O_valid,
   input  lane_onehot_t     O_ready
);

   buf_state_e       state_q, state_d;
   logic [WIDTH-1:0] head_data_q, head_data_d;
   lane_onehot_t     head_dest_q, head_dest_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   lane_onehot_t     skid_dest_q, skid_dest_d;
   logic             ready_q;

   lane_onehot_t     in_dest_s;
   logic             push_s;
   logic             pop_s;
   logic [WIDTH-1:0] lane_data_s [N_LANES];

   onehot_decoder u_dec (
      .sel_i    (S),
      .onehot_o (in_dest_s)
   );

   assign push_s = I_valid & ready_q;
   // Masking with O_valid makes ready bits of unselected lanes irrelevant.
   assign pop_s  = |(O_valid & O_ready);

   // Buffer occupancy and head/skid next-state.
   always_comb begin
      state_d     = state_q;
      head_data_d = head_data_q;
      head_dest_d = head_dest_q;
      skid_data_d = skid_data_q;
      skid_dest_d = skid_dest_q;
      case (state_q)
         EMPTY: begin
            if (push_s) begin
               state_d     = ONE;
               head_data_d = I;
               head_dest_d = in_dest_s;
            end else begin
               state_d = EMPTY;
            end
         end
         ONE: begin
            if (push_s && pop_s) begin
               // Outgoing head is replaced in place: no bubble.
               head_data_d = I;
               head_dest_d = in_dest_s;
            end else if (push_s) begin
               state_d     = FULL;
               skid_data_d = I;
               skid_dest_d = in_dest_s;
            end else if (pop_s) begin
               state_d = EMPTY;
            end else begin
               state_d = ONE;
            end
         end
         FULL: begin
            // I_ready is low here, so only a pop can happen.
            if (pop_s) begin
               state_d     = ONE;
               head_data_d = skid_data_q;
               head_dest_d = skid_dest_q;
            end else begin
               state_d = FULL;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   // Buffer registers and input ready; ready tracks the next occupancy.
   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         state_q     <= EMPTY;
         head_data_q <= '0;
         head_dest_q <= 8'b0000_0000;
         skid_data_q <= '0;
         skid_dest_q <= 8'b0000_0000;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_data_q <= head_data_d;
         head_dest_q <= head_dest_d;
         skid_data_q <= skid_data_d;
         skid_dest_q <= skid_dest_d;
         ready_q     <= (state_d != FULL);
      end
   end

   assign I_ready = ready_q;
   assign O_valid = (state_q != EMPTY) ? head_dest_q : 8'b0000_0000;

   // Only the valid lane carries head data; the rest drive zero.
   always_comb begin
      for (int k = 0; k < N_LANES; k++) begin
         lane_data_s[k] = O_valid[k] ? head_data_q : '0;
      end
   end

   assign O0 = lane_data_s[0];
   assign O1 = lane_data_s[1];
   assign O2 = lane_data_s[2];
   assign O3 = lane_data_s[3];
   assign O4 = lane_data_s[4];
   assign O5 = lane_data_s[5];
   assign O6 = lane_data_s[6];
   assign O7 = lane_data_s[7];

endmodule : onehot_demux_stream

// File: tb/tb_onehot_demux_stream.sv
// Directed self-checking bench for onehot_demux_stream (WIDTH = 4).
module tb_onehot_demux_stream;

   localparam int W = 4;

   logic         CLK = 1'b0;
   logic         ASYNCRESET;
   logic [W-1:0] I;
   logic [2:0]   S;
   logic         I_valid;
   logic         I_ready;
   logic [W-1:0] O0, O1, O2, O3, O4, O5, O6, O7;
   logic [7:0]   O_valid;
   logic [7:0]   O_ready;

   int checks = 0;
   int errors = 0;

   onehot_demux_stream #(.WIDTH(W)) dut (
      .CLK        (CLK),
      .ASYNCRESET (ASYNCRESET),
      .I          (I),
      .S          (S),
      .I_valid    (I_valid),
      .I_ready    (I_ready),
      .O0         (O0),
      .O1         (O1),
      .O2         (O2),
      .O3         (O3),
      .O4         (O4),
      .O5         (O5),
      .O6         (O6),
      .O7         (O7),
      .O_valid    (O_valid),
      .O_ready    (O_ready)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected {O7..O0}: data d on lane 'lane', zeros elsewhere; lane < 0 means idle.
   function automatic logic [8*W-1:0] exp_lanes(input int lane, input logic [W-1:0] d);
      logic [8*W-1:0] v;
      v = '0;
      if (lane >= 0) v[lane*W +: W] = d;
      return v;
   endfunction

   task automatic chk_out(input string tag, input logic [7:0] ov, input int lane,
                          input logic [W-1:0] d, input logic rdy);
      chk({tag, ".valid"}, {56'd0, O_valid}, {56'd0, ov});
      chk({tag, ".lanes"}, {32'd0, O7, O6, O5, O4, O3, O2, O1, O0}, {32'd0, exp_lanes(lane, d)});
      chk({tag, ".ready"}, {63'd0, I_ready}, {63'd0, rdy});
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 ns later.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      ASYNCRESET = 1'b1;
      I          = 4'd0;
      S          = 3'd0;
      I_valid    = 1'b0;
      O_ready    = 8'hFF;
      #1;
      chk_out("rst_async", 8'h00, -1, 4'd0, 1'b0);
      step();
      step();
      chk_out("rst_held", 8'h00, -1, 4'd0, 1'b0);
      ASYNCRESET = 1'b0;
      step();
      chk_out("rst_release", 8'h00, -1, 4'd0, 1'b1);

      // Single push to lane 5, consumer ready: one cycle of valid.
      I = 4'd1; S = 3'd5; I_valid = 1'b1;
      step();
      I_valid = 1'b0;
      chk_out("single_on", 8'b0010_0000, 5, 4'd1, 1'b1);
      step();
      chk_out("single_off", 8'h00, -1, 4'd0, 1'b1);

      // Back-to-back lanes 0..7, one word per cycle.
      for (int i = 0; i < 8; i++) begin
         I = 4'(i + 1); S = 3'(i); I_valid = 1'b1;
         step();
         chk_out($sformatf("b2b_%0d", i), 8'(1 << i), i, 4'(i + 1), 1'b1);
      end
      I_valid = 1'b0;
      step();
      chk_out("b2b_drain", 8'h00, -1, 4'd0, 1'b1);

      // Lane 3 stalled: push lane 3 then lane 6 to fill the buffer.
      O_ready = 8'b1111_0111;
      I = 4'hA; S = 3'd3; I_valid = 1'b1;
      step();
      chk_out("stall_one", 8'b0000_1000, 3, 4'hA, 1'b1);
      I = 4'hB; S = 3'd6;
      step();
      I_valid = 1'b0;
      chk_out("stall_full", 8'b0000_1000, 3, 4'hA, 1'b0);
      step();
      chk_out("stall_hold", 8'b0000_1000, 3, 4'hA, 1'b0);
      O_ready = 8'hFF;
      step();
      chk_out("stall_skid", 8'b0100_0000, 6, 4'hB, 1'b1);
      step();
      chk_out("stall_drain", 8'h00, -1, 4'd0, 1'b1);

      // Head on lane 2, every other lane ready: must not pop.
      O_ready = 8'b1111_1011;
      I = 4'h7; S = 3'd2; I_valid = 1'b1;
      step();
      I_valid = 1'b0;
      chk_out("unsel_0", 8'b0000_0100, 2, 4'h7, 1'b1);
      step();
      chk_out("unsel_1", 8'b0000_0100, 2, 4'h7, 1'b1);
      O_ready = 8'hFF;
      step();
      chk_out("unsel_drain", 8'h00, -1, 4'd0, 1'b1);

      // Push and pop together from ONE: head replaced, no bubble.
      I = 4'h3; S = 3'd1; I_valid = 1'b1;
      step();
      chk_out("pp_one", 8'b0000_0010, 1, 4'h3, 1'b1);
      I = 4'h9; S = 3'd4;
      step();
      I_valid = 1'b0;
      chk_out("pp_replace", 8'b0001_0000, 4, 4'h9, 1'b1);
      step();
      chk_out("pp_drain", 8'h00, -1, 4'd0, 1'b1);

      // Fill to FULL, then reset mid-cycle.
      O_ready = 8'h00;
      I = 4'h5; S = 3'd0; I_valid = 1'b1;
      step();
      I = 4'h6; S = 3'd7;
      step();
      I_valid = 1'b0;
      chk_out("midrst_full", 8'b0000_0001, 0, 4'h5, 1'b0);
      #3;
      ASYNCRESET = 1'b1;
      #1;
      chk_out("midrst_clear", 8'h00, -1, 4'd0, 1'b0);
      #2;
      ASYNCRESET = 1'b0;
      O_ready = 8'hFF;
      step();
      chk_out("midrst_after0", 8'h00, -1, 4'd0, 1'b1);
      step();
      chk_out("midrst_after1", 8'h00, -1, 4'd0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_onehot_demux_stream
